// File: rtl/npu_pkg.sv
// Shared types and constants for the NPU dot-product sequencer.
package npu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } npu_state_e;

    localparam int unsigned RD_LAT     = 1;
    localparam int unsigned DSP_LAT    = 2;
    localparam int unsigned DSP_OUT_W  = 37;
    localparam int unsigned OPND_W     = 18;
    localparam int unsigned PAIR_W     = 2 * OPND_W;
    localparam int unsigned PIPE_DEPTH = RD_LAT + DSP_LAT;
    localparam int unsigned ACC_MAX_W  = 64;

    // One buffer word: element 2k in the low lane, element 2k+1 in the high lane.
    typedef struct packed {
        logic [OPND_W-1:0] hi;
        logic [OPND_W-1:0] lo;
    } opnd_pair_t;

    // Sign-extend a DSP result to the widest supported accumulator; callers narrow to ACC_W.
    function automatic logic [ACC_MAX_W-1:0] sext_dsp(input logic [DSP_OUT_W-1:0] x);
        return {{(ACC_MAX_W - DSP_OUT_W){x[DSP_OUT_W-1]}}, x};
    endfunction

endpackage

// File: rtl/npu_valid_pipe.sv
// Tracks which cycles carry live read data / DSP results, plus the odd-length upper-lane mask.
module npu_valid_pipe #(
    parameter int unsigned DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             in_mask,
    output logic [DEPTH-1:0] valid,
    output logic             head_mask
);

    // Stage 0 is the read-data cycle; the mask is only consumed there.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid     <= '0;
            head_mask <= 1'b0;
        end else begin
            valid     <= DEPTH'({valid, in_valid});
            head_mask <= in_valid & in_mask;
        end
    end

endmodule

// File: rtl/npu_dot_seq.sv
// Streams a signed 18-bit dot product through one dual-lane multiply-add DSP and
// returns the accumulated result over a valid/ready handshake.
module npu_dot_seq
    import npu_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned ACC_W  = 48   // 37..64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDR_W+1:0]    len,
    output logic                 busy,
    output logic                 a_rd_en,
    output logic [ADDR_W-1:0]    a_rd_addr,
    input  logic [PAIR_W-1:0]    a_rd_data,
    output logic                 b_rd_en,
    output logic [ADDR_W-1:0]    b_rd_addr,
    input  logic [PAIR_W-1:0]    b_rd_data,
    output logic [OPND_W-1:0]    dsp_a0,
    output logic [OPND_W-1:0]    dsp_b0,
    output logic [OPND_W-1:0]    dsp_a1,
    output logic [OPND_W-1:0]    dsp_b1,
    output logic                 dsp_ce,
    output logic                 dsp_reset,
    input  logic [DSP_OUT_W-1:0] dsp_dout,
    output logic [ACC_W-1:0]     res_data,
    output logic                 res_valid,
    input  logic                 res_ready
);

    localparam int unsigned LEN_W = ADDR_W + 2;

    npu_state_e             state;
    logic                   busy_q;
    logic                   rd_en_q;
    logic [ADDR_W-1:0]      rd_addr_q;
    logic [ADDR_W-1:0]      last_addr_q;
    logic                   n_odd_q;
    logic [ACC_W-1:0]       acc_q;

    logic [LEN_W-1:0]       pairs_c;
    logic [ADDR_W-1:0]      last_addr_c;
    logic                   odd_issue_c;
    logic [ACC_W-1:0]       acc_next_c;
    logic                   drain_done_c;
    logic [PIPE_DEPTH-1:0]  pipe_valid;
    logic                   head_mask;
    opnd_pair_t             a_pair;
    opnd_pair_t             b_pair;

    assign busy      = busy_q;
    assign dsp_ce    = busy_q;
    assign a_rd_en   = rd_en_q;
    assign b_rd_en   = rd_en_q;
    assign a_rd_addr = rd_addr_q;
    assign b_rd_addr = rd_addr_q;
    assign a_pair    = a_rd_data;
    assign b_pair    = b_rd_data;

    // Last pair address is ceil(N/2)-1; only meaningful for N > 0.
    assign pairs_c     = LEN_W'((len + LEN_W'(1)) >> 1);
    assign last_addr_c = ADDR_W'(pairs_c - LEN_W'(1));

    assign odd_issue_c  = rd_en_q & n_odd_q & (rd_addr_q == last_addr_q);
    assign drain_done_c = (pipe_valid[PIPE_DEPTH-2:0] == '0);

    npu_valid_pipe #(
        .DEPTH (PIPE_DEPTH)
    ) u_valid_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (rd_en_q),
        .in_mask   (odd_issue_c),
        .valid     (pipe_valid),
        .head_mask (head_mask)
    );

    // Operands pass straight from the buffers to the DSP input register; idle cycles feed zeros.
    always_comb begin
        dsp_a0 = '0;
        dsp_b0 = '0;
        dsp_a1 = '0;
        dsp_b1 = '0;
        if (pipe_valid[0]) begin
            dsp_a0 = a_pair.lo;
            dsp_b0 = b_pair.lo;
            if (!head_mask) begin
                dsp_a1 = a_pair.hi;
                dsp_b1 = b_pair.hi;
            end
        end
    end

    // Accumulator input: the DSP output is only live in the last pipe stage.
    always_comb begin
        acc_next_c = acc_q;
        if (pipe_valid[PIPE_DEPTH-1]) begin
            acc_next_c = acc_q + ACC_W'(sext_dsp(dsp_dout));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            last_addr_q <= '0;
            n_odd_q     <= 1'b0;
            acc_q       <= '0;
            res_data    <= '0;
            res_valid   <= 1'b0;
            dsp_reset   <= 1'b1;
        end else begin
            dsp_reset <= 1'b0;
            acc_q     <= acc_next_c;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (len == '0) begin
                            res_data  <= '0;
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            last_addr_q <= last_addr_c;
                            n_odd_q     <= len[0];
                            acc_q       <= '0;
                            rd_en_q     <= 1'b1;
                            rd_addr_q   <= '0;
                            state       <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (rd_addr_q == last_addr_q) begin
                        rd_en_q   <= 1'b0;
                        rd_addr_q <= '0;
                        state     <= DRAIN;
                    end else begin
                        rd_addr_q <= rd_addr_q + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // Final DSP result is added in the same edge that publishes the sum.
                    if (drain_done_c) begin
                        res_data  <= acc_next_c;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy_q    <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npu_dot_seq.sv
// Bench for npu_dot_seq: buffer and DSP models around the DUT, integer dot-product reference.
module tb_npu_dot_seq;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned ACC_W  = 48;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W+1:0] len = '0;
    logic              busy;
    logic              a_rd_en, b_rd_en;
    logic [ADDR_W-1:0] a_rd_addr, b_rd_addr;
    logic [35:0]       a_rd_data = '0;
    logic [35:0]       b_rd_data = '0;
    logic [17:0]       dsp_a0, dsp_b0, dsp_a1, dsp_b1;
    logic              dsp_ce, dsp_reset;
    logic [36:0]       dsp_dout;
    logic [ACC_W-1:0]  res_data;
    logic              res_valid;
    logic              res_ready = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [35:0] a_mem [32];
    logic [35:0] b_mem [32];
    int          a_el [64];
    int          b_el [64];

    int          rd_a_cnt = 0;
    int          rd_b_cnt = 0;
    logic [ADDR_W-1:0] mon_last = '0;
    logic        prev_last = 1'b0;
    logic        last_seen = 1'b0;
    logic [17:0] last_a1 = '0;
    logic [17:0] last_b1 = '0;

    npu_dot_seq #(
        .ADDR_W (ADDR_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .a_rd_en   (a_rd_en),
        .a_rd_addr (a_rd_addr),
        .a_rd_data (a_rd_data),
        .b_rd_en   (b_rd_en),
        .b_rd_addr (b_rd_addr),
        .b_rd_data (b_rd_data),
        .dsp_a0    (dsp_a0),
        .dsp_b0    (dsp_b0),
        .dsp_a1    (dsp_a1),
        .dsp_b1    (dsp_b1),
        .dsp_ce    (dsp_ce),
        .dsp_reset (dsp_reset),
        .dsp_dout  (dsp_dout),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    always #5 clk = ~clk;

    // Operand buffers: one-cycle registered read.
    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
        if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
    end

    // DSP: input register then output register, synchronous reset, clock enable.
    logic [17:0] in_a0 = '0, in_b0 = '0, in_a1 = '0, in_b1 = '0;
    logic [36:0] dout_q = '0;
    assign dsp_dout = dout_q;

    function automatic logic [36:0] mac2(input logic [17:0] x0, input logic [17:0] y0,
                                         input logic [17:0] x1, input logic [17:0] y1);
        longint s;
        s = longint'($signed(x0)) * longint'($signed(y0)) + longint'($signed(x1)) * longint'($signed(y1));
        return 37'(s);
    endfunction

    always @(posedge clk) begin
        if (dsp_reset) begin
            in_a0 <= '0; in_b0 <= '0; in_a1 <= '0; in_b1 <= '0; dout_q <= '0;
        end else if (dsp_ce) begin
            in_a0 <= dsp_a0; in_b0 <= dsp_b0; in_a1 <= dsp_a1; in_b1 <= dsp_b1;
            dout_q <= mac2(in_a0, in_b0, in_a1, in_b1);
        end
    end

    // Read counting and capture of the upper lane in the last pair's data cycle.
    always @(negedge clk) begin
        if (prev_last) begin
            last_a1   = dsp_a1;
            last_b1   = dsp_b1;
            last_seen = 1'b1;
        end
        prev_last = a_rd_en && (a_rd_addr == mon_last);
        if (a_rd_en) rd_a_cnt++;
        if (b_rd_en) rd_b_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer dot product over the first n elements, wrapped to ACC_W.
    function automatic logic [ACC_W-1:0] ref_dot(input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) s += longint'(a_el[i]) * longint'(b_el[i]);
        return ACC_W'(s);
    endfunction

    task automatic load_mem(input int n);
        for (int k = 0; k < 32; k++) begin
            a_mem[k] = {18'(a_el[2*k+1]), 18'(a_el[2*k])};
            b_mem[k] = {18'(b_el[2*k+1]), 18'(b_el[2*k])};
        end
        rd_a_cnt  = 0;
        rd_b_cnt  = 0;
        prev_last = 1'b0;
        last_seen = 1'b0;
        mon_last  = ADDR_W'((n + 1) / 2 - 1);
    endtask

    task automatic randomize_elems();
        logic [17:0] r;
        for (int i = 0; i < 64; i++) begin
            r = 18'($urandom); a_el[i] = int'($signed(r));
            r = 18'($urandom); b_el[i] = int'($signed(r));
        end
    endtask

    // Launch at a negedge, wait for res_valid; returns the cycle index where it rose (edge 0 = start).
    task automatic launch_and_wait(input int n, output int cyc);
        len   = (ADDR_W + 2)'(n);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!res_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run(input string tag, input int n, input int ready_wait);
        int cyc;
        int p;
        logic [ACC_W-1:0] expv;
        p    = (n + 1) / 2;
        expv = ref_dot(n);
        load_mem(n);
        res_ready = (ready_wait == 0);
        launch_and_wait(n, cyc);
        chk({tag, "_valid"}, res_valid, 1);
        chk({tag, "_latency"}, cyc, (n == 0) ? 1 : p + 4);
        chk({tag, "_data"}, res_data, expv);
        repeat (ready_wait) @(negedge clk);
        if (ready_wait > 0) chk({tag, "_held_data"}, res_data, expv);
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_valid_after"}, res_valid, 0);
        chk({tag, "_a_reads"}, rd_a_cnt, p);
        chk({tag, "_b_reads"}, rd_b_cnt, p);
        if (n % 2 == 1) begin
            chk({tag, "_last_seen"}, last_seen, 1);
            chk({tag, "_last_a1"}, last_a1, 0);
            chk({tag, "_last_b1"}, last_b1, 0);
        end
    endtask

    initial begin
        int cyc;
        int saw_valid;
        logic [ACC_W-1:0] expv;

        for (int i = 0; i < 64; i++) begin a_el[i] = 0; b_el[i] = 0; end

        // Reset values
        #2 reset_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", {a_rd_en, b_rd_en}, 0);
        chk("rst_addr", {a_rd_addr, b_rd_addr}, 0);
        chk("rst_dsp_ce", dsp_ce, 0);
        chk("rst_dsp_reset", dsp_reset, 1);
        chk("rst_res", {res_valid, res_data}, 0);
        chk("rst_opnds", {dsp_a0, dsp_b0, dsp_a1, dsp_b1}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1 chk("rel_dsp_reset_first", dsp_reset, 1);
        @(negedge clk);
        chk("rel_dsp_reset_after", dsp_reset, 0);

        // N=4: 1*5+2*6+3*7+4*8 = 70
        a_el[0:3] = '{1, 2, 3, 4};
        b_el[0:3] = '{5, 6, 7, 8};
        run("n4", 4, 0);

        // N=3 with a poisoned upper lane in the last pair: 5+12+21 = 38
        a_el[0:3] = '{1, 2, 3, 131071};
        b_el[0:3] = '{5, 6, 7, 131071};
        run("n3", 3, 0);

        // N=64 at the most negative operand: 64 * 2^34 = 2^40
        for (int i = 0; i < 64; i++) begin a_el[i] = -131072; b_el[i] = -131072; end
        run("n64", 64, 0);
        chk("n64_value", res_data, 48'h0100_0000_0000);

        // N=0: immediate zero result, no reads
        run("n0", 0, 0);

        // N=2 with backpressure and an ignored start pulse: -21 + -8 = -29
        a_el[0:1] = '{-3, 4};
        b_el[0:1] = '{7, -2};
        expv = ref_dot(2);
        load_mem(2);
        res_ready = 1'b0;
        launch_and_wait(2, cyc);
        chk("bp_latency", cyc, 5);
        chk("bp_data", res_data, expv);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = (i == 2);
            len   = 7'd4;
            chk("bp_hold_valid", res_valid, 1);
            chk("bp_hold_data", res_data, expv);
        end
        res_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("bp_busy_fall", busy, 0);
        @(negedge clk);
        chk("bp_no_restart", {busy, a_rd_en}, 0);
        chk("bp_reads", rd_a_cnt, 1);

        // Asynchronous reset in the second ISSUE cycle of an N=8 run
        randomize_elems();
        load_mem(8);
        len   = 7'd8;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_pre_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", {a_rd_en, b_rd_en}, 0);
        chk("abort_addr", {a_rd_addr, b_rd_addr}, 0);
        chk("abort_dsp", {dsp_ce, dsp_reset}, 2'b01);
        chk("abort_opnds", {dsp_a0, dsp_b0, dsp_a1, dsp_b1}, 0);
        chk("abort_res", {res_valid, res_data}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("abort_dsp_reset_rel", dsp_reset, 1);
        saw_valid = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid || busy) saw_valid++;
        end
        chk("abort_no_result", saw_valid, 0);
        for (int i = 0; i < 64; i++) begin a_el[i] = 0; b_el[i] = 0; end
        a_el[0:1] = '{1, 1};
        b_el[0:1] = '{1, 1};
        run("post_abort", 2, 0);
        chk("post_abort_value", res_data, 48'd2);

        // Randomized lengths, data and consumer stalls
        for (int t = 0; t < 8; t++) begin
            randomize_elems();
            run($sformatf("rand%0d", t), int'($urandom_range(1, 64)), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
